stream_repeat_step: RTL and testbench
=====================================

# stream_repeat_step

Parametrised stream generator: accepts one scalar load (value, step, count) on a valid/ready input channel and emits a stream of `value, value+step, value+2*step, …` on a valid/ready output channel.
- Count 0 selects an unbounded stream, ended only by `stop`; a nonzero count ends the stream after that many elements.
- It is the general form of the fixed-width, constant-value repeat block. Generated and hand-written pipelines use it wherever a scalar must be fanned out into a stream.

## Interface
Parameters:
- `N`, 8, data width (value, step, output)
- `CW`, 16, element-count width

Ports:
- `clk`  in  1  clock, rising edge
- `nrst`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  load request
- `in_ready`  out  1  load accepted when high with `in_valid`
- `in_value`  in  N  first element
- `in_step`  in  N  increment per element; 0 gives a pure repeat
- `in_count`  in  CW  number of elements; 0 means unbounded
- `stop`  in  1  level; marks the current element as last
- `out_valid`  out  1  element available
- `out_ready`  in  1  consumer accepts element
- `out_data`  out  N  current element
- `out_last`  out  1  current element is final
- `busy`  out  1  stream in progress (state RUN)

## Operation
- State machine has two states: IDLE and RUN.
- Registers:
  - `cur` (N bits)
  - `stp` (N bits)
  - `rem` (CW bits)
  - `inf` (1 bit)
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - Load fires on `in_valid & in_ready`: `cur`←`in_value`, `stp`←`in_step`, `rem`←`in_count`, `inf`←(`in_count`==0), next state RUN.
- RUN:
  - `out_valid`=1, `out_data`=`cur`.
  - `out_last` = `stop` | (!`inf` & `rem`==1).
- Output handshake fires on `out_valid & out_ready`:
  - `cur` ← `cur`+`stp`, truncated modulo 2^N (wrap, no saturation).
  - If !`inf`: `rem` ← `rem`-1.
  - If `out_last` was high: leave RUN.
- Back-to-back loads:
  - In RUN, `in_ready` = `out_ready & out_last`. This is a combinational path from `out_ready`/`stop` to `in_ready`, and is intended.
  - If a load fires in the same cycle as the final output handshake, the new parameters are loaded and the state stays RUN, so there is no bubble.
  - Otherwise the block returns to IDLE.
- `stop`:
  - Sampled only in RUN, and only takes effect on a handshake.
  - If `stop` drops before a handshake, the stream continues.
  - `stop` in IDLE is ignored.
  - `stop` also applies to bounded streams, ending them early.
- Without a handshake, `out_data`/`out_last`/`rem` hold, except that `out_last` follows `stop` combinationally.
- `busy` = (state==RUN).

## Timing
- Reset (`nrst` low, asynchronous):
  - state IDLE; `cur`, `stp`, `rem`, `inf` ← 0.
  - Outputs: `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0.
  - `in_ready` is forced 0 while `nrst` is low and becomes 1 in the first cycle after release.
- Latency: a load at edge k gives the first element valid in the cycle after edge k.
- Throughput: one element per cycle with `out_ready` held high; zero-bubble across back-to-back loads.
- Reset mid-stream aborts immediately. No partial element and no `out_last` is emitted.
- Maximum bounded length is 2^CW−1. `rem` never underflows, because the exit happens at `rem`==1.
- Both handshakes are evaluated on the same rising edge. The output handshake updates are applied first, then the load overrides all registers.

## Test plan
- Unbounded repeat: load value=42, step=0, count=0, `out_ready`=1, `stop`=0.
  - Expect `out_data`=42 with `out_valid`=1 on every cycle for ≥5 cycles, `out_last`=0, `in_ready`=0.
- Bounded with wrap: N=8, load value=250, step=3, count=4.
  - Expect 250, 253, 0, 3 on consecutive cycles, with `out_last`=1 only on 3.
  - Then `out_valid`=0, `busy`=0, `in_ready`=1.
- Backpressure: load value=10, step=1, count=3 with `out_ready` pattern 1,0,0,1,0,1.
  - Expect 10 accepted, 11 held for two cycles, 11 accepted, 12 held, 12 accepted with `out_last`=1.
  - `rem` only decrements on accepted cycles.
- Back-to-back: load (5,1,2); hold `in_valid` with (100,0,1) presented during the stream.
  - Expect 5, 6(last), 100(last) on three consecutive cycles.
  - `in_ready` pulses with the 6 handshake; no idle cycle.
- Stop: load value=7, step=2, count=0; assert `stop` on the 3rd element.
  - Expect 7, 9, 11 with `out_last`=1 on 11; then IDLE.
  - A separate `stop` pulse while `out_ready`=0 has no effect once `stop` drops.
- Reset mid-stream: load (1,1,10); pull `nrst` low after the 3rd element.
  - Expect `out_valid`/`out_data`/`busy` at 0 immediately (asynchronous).
  - After release, the next load of (20,0,1) yields a single 20 with `out_last`=1.

Source files
------------

// File: rtl/stream_repeat_step.sv
// Scalar-to-stream generator: value, value+step, ... for count elements (0 = until stop).
// First element valid the cycle after the load; holds on !out_ready; reloads with no bubble.
module stream_repeat_step #(
   parameter int N  = 8,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_value,
   input  logic [N-1:0]  in_step,
   input  logic [CW-1:0] in_count,
   input  logic          stop,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_data,
   output logic          out_last,
   output logic          busy
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t        state, state_nxt;
   logic [N-1:0]  cur, cur_nxt;
   logic [N-1:0]  stp, stp_nxt;
   logic [CW-1:0] rem, rem_nxt;
   logic          inf, inf_nxt;
   logic          run;
   logic          out_fire;
   logic          in_fire;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= IDLE;
         cur   <= '0;
         stp   <= '0;
         rem   <= '0;
         inf   <= 1'b0;
      end else begin
         state <= state_nxt;
         cur   <= cur_nxt;
         stp   <= stp_nxt;
         rem   <= rem_nxt;
         inf   <= inf_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cur_nxt   = cur;
      stp_nxt   = stp;
      rem_nxt   = rem;
      inf_nxt   = inf;

      run       = (state == RUN);
      out_valid = run;
      out_data  = run ? cur : '0;
      out_last  = run & (stop | (!inf & (rem == CW'(1))));
      busy      = run;

      // Reload is only possible while idle or on the final accepted element.
      in_ready  = nrst & (!run | (out_ready & out_last));
      out_fire  = out_valid & out_ready;
      in_fire   = in_valid & in_ready;

      if (out_fire) begin
         cur_nxt = cur + stp;
         if (!inf)
            rem_nxt = rem - CW'(1);
         if (out_last)
            state_nxt = IDLE;
      end

      // A load on the same edge overrides the advance above.
      if (in_fire) begin
         cur_nxt   = in_value;
         stp_nxt   = in_step;
         rem_nxt   = in_count;
         inf_nxt   = (in_count == '0);
         state_nxt = RUN;
      end
   end

endmodule

// File: tb/tb_stream_repeat_step.sv
// Directed vector bench for stream_repeat_step: one table row per clock cycle plus a reset-abort sequence.
module tb_stream_repeat_step;

   logic        clk = 1'b0;
   logic        nrst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_value;
   logic [7:0]  in_step;
   logic [15:0] in_count;
   logic        stop;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_last;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   stream_repeat_step #(.N(8), .CW(16)) dut (
      .clk(clk), .nrst(nrst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_value(in_value), .in_step(in_step), .in_count(in_count),
      .stop(stop),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .busy(busy)
   );

   typedef struct {
      logic        iv;
      logic [7:0]  val;
      logic [7:0]  stp;
      logic [15:0] cnt;
      logic        stp_lvl;
      logic        ordy;
      logic        e_irdy;
      logic        e_ov;
      logic [7:0]  e_data;
      logic        e_last;
      logic        e_busy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic iv, logic [7:0] val, logic [7:0] st, logic [15:0] cnt,
                               logic sl, logic ordy, logic e_irdy, logic e_ov,
                               logic [7:0] e_data, logic e_last, logic e_busy);
      vec_t v;
      v.iv = iv; v.val = val; v.stp = st; v.cnt = cnt; v.stp_lvl = sl; v.ordy = ordy;
      v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_data = e_data; v.e_last = e_last; v.e_busy = e_busy;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic irdy, input logic ov,
                            input logic [7:0] d, input logic l, input logic b);
      check({tag, ".in_ready"},  32'(in_ready),  32'(irdy));
      check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
      check({tag, ".out_data"},  32'(out_data),  32'(d));
      check({tag, ".out_last"},  32'(out_last),  32'(l));
      check({tag, ".busy"},      32'(busy),      32'(b));
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //                 iv val  stp cnt stop ordy | irdy ov data last busy
      // unbounded repeat of 42, ended by stop
      vecs.push_back(mk(1, 42,  0, 0, 0, 1,  1, 0,   0, 0, 0));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 1,  42, 0, 1));
      vecs.push_back(mk(0, 0,   0, 0, 1, 1,  1, 1,  42, 1, 1));
      // bounded with wrap: 250, 253, 0, 3
      vecs.push_back(mk(1, 250, 3, 4, 0, 1,  1, 0,   0, 0, 0));
      vecs.push_back(mk(0, 0,   0, 0, 0, 1,  0, 1, 250, 0, 1));
      vecs.push_back(mk(0, 0,   0, 0, 0, 1,  0, 1, 253, 0, 1));
      vecs.push_back(mk(0, 0,   0, 0, 0, 1,  0, 1,   0, 0, 1));
      vecs.push_back(mk(0, 0,   0, 0, 0, 1,  1, 1,   3, 1, 1));
      vecs.push_back(mk(0, 0,   0, 0, 0, 0,  1, 0,   0, 0, 0));
      // backpressure: out_ready 1,0,0,1,0,1
      vecs.push_back(mk(1, 10,  1, 3, 0, 0,  1, 0,   0, 0, 0));
      vecs.push_back(mk(0, 0,   0, 0, 0, 1,  0, 1,  10, 0, 1));
      vecs.push_back(mk(0, 0,   0, 0, 0, 0,  0, 1,  11, 0, 1));
      vecs.push_back(mk(0, 0,   0, 0, 0, 0,  0, 1,  11, 0, 1));
      vecs.push_back(mk(0, 0,   0, 0, 0, 1,  0, 1,  11, 0, 1));
      vecs.push_back(mk(0, 0,   0, 0, 0, 0,  0, 1,  12, 1, 1));
      vecs.push_back(mk(0, 0,   0, 0, 0, 1,  1, 1,  12, 1, 1));
      vecs.push_back(mk(0, 0,   0, 0, 0, 1,  1, 0,   0, 0, 0));
      // back-to-back: (5,1,2) then (100,0,1) with no bubble
      vecs.push_back(mk(1, 5,   1, 2, 0, 1,  1, 0,   0, 0, 0));
      vecs.push_back(mk(1, 100, 0, 1, 0, 1,  0, 1,   5, 0, 1));
      vecs.push_back(mk(1, 100, 0, 1, 0, 1,  1, 1,   6, 1, 1));
      vecs.push_back(mk(0, 0,   0, 0, 0, 1,  1, 1, 100, 1, 1));
      vecs.push_back(mk(0, 0,   0, 0, 0, 1,  1, 0,   0, 0, 0));
      // stop on the third element of an unbounded stream
      vecs.push_back(mk(1, 7,   2, 0, 0, 1,  1, 0,   0, 0, 0));
      vecs.push_back(mk(0, 0,   0, 0, 0, 1,  0, 1,   7, 0, 1));
      vecs.push_back(mk(0, 0,   0, 0, 0, 1,  0, 1,   9, 0, 1));
      vecs.push_back(mk(0, 0,   0, 0, 1, 1,  1, 1,  11, 1, 1));
      vecs.push_back(mk(0, 0,   0, 0, 0, 1,  1, 0,   0, 0, 0));
      // stop pulse without a handshake must not end the stream
      vecs.push_back(mk(1, 7,   2, 0, 0, 1,  1, 0,   0, 0, 0));
      vecs.push_back(mk(0, 0,   0, 0, 0, 1,  0, 1,   7, 0, 1));
      vecs.push_back(mk(0, 0,   0, 0, 1, 0,  0, 1,   9, 1, 1));
      vecs.push_back(mk(0, 0,   0, 0, 0, 0,  0, 1,   9, 0, 1));
      vecs.push_back(mk(0, 0,   0, 0, 0, 1,  0, 1,   9, 0, 1));
      vecs.push_back(mk(0, 0,   0, 0, 1, 1,  1, 1,  11, 1, 1));
      // stop while idle is ignored
      vecs.push_back(mk(0, 0,   0, 0, 1, 1,  1, 0,   0, 0, 0));
      vecs.push_back(mk(0, 0,   0, 0, 0, 1,  1, 0,   0, 0, 0));

      nrst = 1'b0; in_valid = 1'b0; in_value = '0; in_step = '0; in_count = '0;
      stop = 1'b0; out_ready = 1'b0;
      next_cycle();
      check_all("reset", 0, 0, 8'd0, 0, 0);
      nrst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         in_valid = vecs[i].iv;   in_value = vecs[i].val; in_step = vecs[i].stp;
         in_count = vecs[i].cnt;  stop = vecs[i].stp_lvl; out_ready = vecs[i].ordy;
         #4;
         check_all($sformatf("vec%0d", i), vecs[i].e_irdy, vecs[i].e_ov,
                   vecs[i].e_data, vecs[i].e_last, vecs[i].e_busy);
         next_cycle();
      end

      // reset mid-stream aborts immediately
      in_valid = 1'b1; in_value = 8'd1; in_step = 8'd1; in_count = 16'd10;
      stop = 1'b0; out_ready = 1'b1;
      next_cycle();
      in_valid = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         #4;
         check($sformatf("rst_seq.elem%0d", e), 32'(out_data), 32'(e));
         next_cycle();
      end
      check("rst_seq.pre_abort", 32'(out_data), 32'd4);
      nrst = 1'b0;
      #1;
      check_all("rst_abort", 0, 0, 8'd0, 0, 0);
      next_cycle();
      check_all("rst_held", 0, 0, 8'd0, 0, 0);
      nrst = 1'b1;
      #1;
      check_all("rst_release", 1, 0, 8'd0, 0, 0);
      in_valid = 1'b1; in_value = 8'd20; in_step = 8'd0; in_count = 16'd1;
      next_cycle();
      in_valid = 1'b0;
      #4;
      check_all("post_rst_single", 1, 1, 8'd20, 1, 1);
      next_cycle();
      #4;
      check_all("post_rst_idle", 1, 0, 8'd0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
